// File: rtl/loader_pkg.sv
// Shared types and widths for the program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE,
        ERR
    } loader_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LEN_W          = 16;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into a 32-bit word; word_c already
// contains the byte being accepted this cycle.
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              accept,
    input  logic [BYTE_W-1:0] byte_data,
    output logic              word_full_c,
    output logic [WORD_W-1:0] word_c
);

    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-1:0] word_q;

    // Insert the incoming byte at its lane so the full word is visible on the 4th accept.
    always_comb begin
        word_c      = word_q;
        word_full_c = 1'b0;
        if (accept) begin
            word_c[{cnt_q, 3'b000} +: BYTE_W] = byte_data;
            word_full_c = (cnt_q == CNT_W'(BYTES_PER_WORD - 1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clr) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (accept) begin
            cnt_q  <= cnt_q + CNT_W'(1);
            word_q <= word_c;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: packs bytes into words, writes them to
// instruction memory and holds the core in reset until the image is complete.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned        A_WIDTH    = 32,
    parameter int unsigned        DATA_WIDTH = 32,
    parameter logic [A_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int unsigned        MAX_WORDS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    input  logic                  byte_valid,
    input  logic [BYTE_W-1:0]     byte_data,
    output logic                  byte_ready,
    output logic                  imem_we,
    output logic [A_WIDTH-1:0]    imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wd,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    loader_state_t     state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  word_idx_q;
    logic              idle_like_c;
    logic              len_ok_c;
    logic              load_start_c;
    logic              accept_c;
    logic              last_word_c;
    logic              word_full_c;
    logic [WORD_W-1:0] word_c;

    assign idle_like_c  = (state_q == IDLE) || (state_q == DONE) || (state_q == ERR);
    assign len_ok_c     = (len != '0) && (32'(len) <= 32'(MAX_WORDS));
    assign load_start_c = idle_like_c && start && len_ok_c;
    assign accept_c     = (state_q == LOAD) && byte_valid;
    assign last_word_c  = (word_idx_q == (len_q - LEN_W'(1)));

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr         (load_start_c),
        .accept      (accept_c),
        .byte_data   (byte_data),
        .word_full_c (word_full_c),
        .word_c      (word_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = len_ok_c ? LOAD : ERR;
                end
            end
            LOAD: begin
                if (word_full_c) begin
                    state_d = WRITE;
                end
            end
            WRITE:   state_d = last_word_c ? DONE : LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wd    <= '0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            len_q      <= '0;
            word_idx_q <= '0;
        end else begin
            byte_ready <= (state_d == LOAD);
            imem_we    <= (state_d == WRITE);
            cpu_rst    <= (state_d != DONE);
            busy       <= (state_d == LOAD) || (state_d == WRITE);
            done       <= (state_d == DONE);
            err        <= (state_d == ERR);

            if (load_start_c) begin
                len_q      <= len;
                word_idx_q <= '0;
            end else if (state_q == WRITE) begin
                word_idx_q <= word_idx_q + LEN_W'(1);
            end

            // Address and data hold outside WRITE; they only change when a word completes.
            if (word_full_c) begin
                imem_addr <= BASE_ADDR + (A_WIDTH'(word_idx_q) << 2);
                imem_wd   <= DATA_WIDTH'(word_c);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader against a byte-list image model.
module tb_prog_loader;

    localparam int unsigned MAXW = 1024;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;
    int busy_cycles = 0;
    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;

    prog_loader #(
        .A_WIDTH    (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE),
        .MAX_WORDS  (MAXW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Capture every memory write and count busy cycles mid-cycle.
    always @(negedge clk) begin
        if (imem_we) wr_q.push_back({imem_addr, imem_wd});
        if (busy) busy_cycles++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int l);
        start = 1'b1;
        len   = 16'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic send_bytes(input int first, input int count, input int max_stall, input bit rnd);
        int stall;
        int guard;
        for (int i = 0; i < count; i++) begin
            stall = rnd ? int'($urandom_range(0, max_stall)) : max_stall;
            byte_valid = 1'b0;
            repeat (stall) tick();
            byte_valid = 1'b1;
            byte_data  = tx_q[first + i];
            guard = 0;
            while (!byte_ready && guard < 100) begin
                tick();
                guard++;
            end
            if (guard >= 100) begin
                n_cmp++;
                n_fail++;
                $display("FAIL byte_accept_timeout: byte %0d never accepted, required acceptance within 100 cycles", first + i);
                byte_valid = 1'b0;
                return;
            end
            tick();
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int guard = 0;
        while (!(done || err) && guard < budget) begin
            tick();
            guard++;
        end
        if (guard >= budget) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: done=%0b err=%0b after %0d cycles, required done", done, err, budget);
        end
    endtask

    // Reference image model: word i is bytes 4i..4i+3 little-endian at BASE + 4*(idx0+i).
    function automatic void model_writes(input int first_byte, input int nwords, input int idx0);
        logic [31:0] w;
        logic [31:0] a;
        for (int i = 0; i < nwords; i++) begin
            w = 32'(tx_q[first_byte + 4*i])
              + 32'(tx_q[first_byte + 4*i + 1]) * 32'd256
              + 32'(tx_q[first_byte + 4*i + 2]) * 32'd65536
              + 32'(tx_q[first_byte + 4*i + 3]) * 32'd16777216;
            a = BASE + 32'(4 * (idx0 + i));
            exp_q.push_back({a, w});
        end
    endfunction

    function automatic void rand_image(input int nbytes);
        tx_q.delete();
        for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
    endfunction

    task automatic test_reset();
        logic [70:0] obs;
        logic [70:0] req;
        req = {1'b0, 1'b0, BASE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        rst = 1'b0;
        repeat (3) tick();
        obs = {byte_ready, imem_we, imem_addr, imem_wd, cpu_rst, busy, done, err};
        n_cmp++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL reset_values: got %h required %h", obs, req);
        end
        rst = 1'b1;
        tick();
        pulse_start(3);
        n_cmp++;
        if ({busy, byte_ready, cpu_rst} !== 3'b111) begin
            n_fail++;
            $display("FAIL start_to_load: busy/ready/cpu_rst=%b required 111", {busy, byte_ready, cpu_rst});
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        obs = {byte_ready, imem_we, imem_addr, imem_wd, cpu_rst, busy, done, err};
        n_cmp++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL async_reset_values: got %h required %h", obs, req);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        tx_q = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};
        wr_q.delete();
        exp_q.delete();
        model_writes(0, 2, 0);
        busy_cycles = 0;
        pulse_start(2);
        send_bytes(0, 8, 0, 1'b0);
        n_cmp++;
        if ({imem_we, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_last_write: we/done=%b required 10", {imem_we, done});
        end
        tick();
        n_cmp++;
        if ({done, cpu_rst, imem_we, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL basic_done: done/cpu_rst/we/busy=%b required 1000", {done, cpu_rst, imem_we, busy});
        end
        n_cmp++;
        if (busy_cycles != 10) begin
            n_fail++;
            $display("FAIL basic_load_time: busy %0d cycles required 10", busy_cycles);
        end
        n_cmp++;
        if (wr_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_write_count: got %0d required %0d", wr_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (wr_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL basic_write%0d: got %h required %h", i, wr_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        wr_q.delete();
        exp_q.delete();
        model_writes(0, 2, 0);
        pulse_start(2);
        send_bytes(0, 8, 3, 1'b0);
        wait_done(200);
        n_cmp++;
        if ({done, cpu_rst} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_done: done/cpu_rst=%b required 10", {done, cpu_rst});
        end
        n_cmp++;
        if (wr_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_write_count: got %0d required %0d", wr_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (wr_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL stall_write%0d: got %h required %h", i, wr_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        wr_q.delete();
        exp_q.delete();
        pulse_start(0);
        n_cmp++;
        if ({err, cpu_rst, busy, byte_ready, done} !== 5'b11000) begin
            n_fail++;
            $display("FAIL illegal_len0: err/cpu_rst/busy/ready/done=%b required 11000", {err, cpu_rst, busy, byte_ready, done});
        end
        byte_valid = 1'b1;
        byte_data  = 8'h5a;
        repeat (3) begin
            tick();
            n_cmp++;
            if ({byte_ready, err} !== 2'b01) begin
                n_fail++;
                $display("FAIL illegal_hold: ready/err=%b required 01", {byte_ready, err});
            end
        end
        byte_valid = 1'b0;
        pulse_start(MAXW + 1);
        n_cmp++;
        if ({err, cpu_rst, busy} !== 3'b110) begin
            n_fail++;
            $display("FAIL illegal_over_max: err/cpu_rst/busy=%b required 110", {err, cpu_rst, busy});
        end
        pulse_start(MAXW);
        n_cmp++;
        if ({err, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL legal_max_len: err/busy=%b required 01", {err, busy});
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        pulse_start(0);
        n_cmp++;
        if (wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL illegal_no_write: got %0d writes required 0", wr_q.size());
        end
        rand_image(4);
        model_writes(0, 1, 0);
        pulse_start(1);
        n_cmp++;
        if ({err, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL illegal_recover: err/busy=%b required 01", {err, busy});
        end
        send_bytes(0, 4, 1, 1'b1);
        wait_done(100);
        n_cmp++;
        if (wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL illegal_recover_write: got %0d writes first %h required 1 write %h",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'h0, exp_q[0]);
        end
    endtask

    task automatic test_reset_midload();
        rand_image(8);
        wr_q.delete();
        exp_q.delete();
        model_writes(0, 1, 0);
        pulse_start(2);
        send_bytes(0, 6, 0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({cpu_rst, imem_we, byte_ready, busy, done} !== 5'b10000) begin
            n_fail++;
            $display("FAIL midload_reset: cpu_rst/we/ready/busy/done=%b required 10000", {cpu_rst, imem_we, byte_ready, busy, done});
        end
        tick();
        rst = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL midload_writes: got %0d writes first %h required 1 write %h",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'h0, exp_q[0]);
        end
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        wr_q.delete();
        exp_q.delete();
        model_writes(0, 1, 0);
        pulse_start(1);
        send_bytes(0, 4, 0, 1'b0);
        wait_done(50);
        n_cmp++;
        if (wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL midload_restart: got %0d writes first %h required 1 write %h",
                     wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'h0, exp_q[0]);
        end
    endtask

    task automatic test_restart();
        rand_image(8);
        wr_q.delete();
        exp_q.delete();
        model_writes(0, 2, 0);
        pulse_start(2);
        send_bytes(0, 2, 0, 1'b0);
        pulse_start(1);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_start_busy: busy=%b required 1", busy);
        end
        send_bytes(2, 6, 1, 1'b1);
        wait_done(100);
        n_cmp++;
        if (wr_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ignored_start_count: got %0d writes required %0d", wr_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (wr_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL ignored_start_write%0d: got %h required %h", i, wr_q[i], exp_q[i]);
                end
            end
        end
        rand_image(4);
        wr_q.delete();
        exp_q.delete();
        model_writes(0, 1, 0);
        pulse_start(1);
        n_cmp++;
        if ({cpu_rst, done, busy} !== 3'b101) begin
            n_fail++;
            $display("FAIL restart_from_done: cpu_rst/done/busy=%b required 101", {cpu_rst, done, busy});
        end
        send_bytes(0, 4, 0, 1'b0);
        n_cmp++;
        if ({imem_we, done, cpu_rst} !== 3'b101) begin
            n_fail++;
            $display("FAIL restart_write_cycle: we/done/cpu_rst=%b required 101", {imem_we, done, cpu_rst});
        end
        tick();
        n_cmp++;
        if ({done, cpu_rst} !== 2'b10 || wr_q.size() != 1 || wr_q[0] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL restart_done: done/cpu_rst=%b writes=%0d first %h required 10, 1 write %h",
                     {done, cpu_rst}, wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 64'h0, exp_q[0]);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(1, 6));
            rand_image(4 * n);
            wr_q.delete();
            exp_q.delete();
            model_writes(0, n, 0);
            pulse_start(n);
            send_bytes(0, 4 * n, 2, 1'b1);
            wait_done(300);
            n_cmp++;
            if (wr_q.size() != exp_q.size()) begin
                n_fail++;
                $display("FAIL random%0d_count: got %0d writes required %0d", it, wr_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_cmp++;
                    if (wr_q[i] !== exp_q[i]) begin
                        n_fail++;
                        $display("FAIL random%0d_write%0d: got %h required %h", it, i, wr_q[i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        len        = 16'h0;
        byte_valid = 1'b0;
        byte_data  = 8'h0;
        test_reset();
        test_basic();
        test_stall();
        test_illegal();
        test_reset_midload();
        test_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that writes a program into instruction memory before the single-cycle core runs. It accepts a byte stream over a valid/ready handshake and packs four bytes, little-endian, into each 32-bit word. Each word goes out on the instruction-memory write port at consecutive word-aligned addresses. The core is held in reset until the whole image has been written.

## Interface
- A_WIDTH, 32, width of instruction-memory byte address
- DATA_WIDTH, 32, instruction word width (fixed at 32; other values unsupported)
- BASE_ADDR, 0, byte address of first word written
- MAX_WORDS, 1024, capacity of instruction memory in words

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a load; sampled in IDLE, DONE, ERR only
- len  in  16  number of words to load, sampled with start
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  next program byte, least-significant byte of each word first
- byte_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write enable, one cycle per word
- imem_addr  out  A_WIDTH  byte address of word being written
- imem_wd  out  32  word being written
- cpu_rst  out  1  active-high reset to the core
- busy  out  1  load in progress (LOAD or WRITE)
- done  out  1  image fully written
- err  out  1  last start had an illegal len

## Operation
- FSM states: IDLE, LOAD, WRITE, DONE, ERR. Outputs are Moore: they are driven only from registered state.
- IDLE: byte_ready=0, cpu_rst=1.
  - start with 1≤len≤MAX_WORDS: latch len, clear word_idx and byte_cnt, go to LOAD.
  - start with len=0 or len>MAX_WORDS: go to ERR.
- LOAD: byte_ready=1.
  - A byte transfer occurs on a clock edge where byte_valid=1 and byte_ready=1.
  - Byte k of a word (k=0..3) goes into bits [8k+7:8k].
  - The 4th transfer goes to WRITE.
- WRITE: one cycle, with byte_ready=0, imem_we=1, imem_addr=BASE_ADDR+4·word_idx, imem_wd=packed word.
  - word_idx is then incremented.
  - If word_idx was len−1, go to DONE; otherwise return to LOAD.
- DONE: done=1, cpu_rst=0, byte_ready=0. Holds until start, which is evaluated as in IDLE.
- ERR: err=1, cpu_rst=1, byte_ready=0. Holds until start, which is evaluated as in IDLE.
- start in LOAD or WRITE is ignored.
- byte_valid outside LOAD is ignored, and no byte is consumed.
- Arithmetic:
  - word_idx and the latched len are 16-bit.
  - The address add is modulo 2^A_WIDTH.
  - imem_addr[1:0] is always 0 when BASE_ADDR is word-aligned.

## Timing
- Reset values: state=IDLE, byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wd=0, cpu_rst=1, busy=0, done=0, err=0.
- Reset asserted mid-load:
  - State returns to IDLE immediately (asynchronous) and any partial word is discarded.
  - No imem_we is asserted afterward.
  - cpu_rst=1.
- start sampled at edge t → LOAD (byte_ready=1) in cycle t+1.
- 4th byte accepted at edge k → imem_we=1 in cycle k+1 only.
- Last WRITE in cycle w → done=1 and cpu_rst=0 from cycle w+1.
- Minimum load time for N words: 5N cycles after LOAD entry (4 byte cycles plus 1 write cycle per word).
- Stalls (byte_valid=0) add cycles without changing data or addresses.
- start in DONE at edge t → busy=1, cpu_rst=1, done=0 in cycle t+1.
- imem_addr and imem_wd hold their last values outside WRITE.

## Structure
- Package loader_pkg contains:
  - typedef enum loader_state_t {IDLE, LOAD, WRITE, DONE, ERR}
  - localparam BYTES_PER_WORD=4
  - localparam LEN_W=16
- Sub-module byte_packer: 2-bit byte counter plus 32-bit shift/insert register.
  - Input: accept strobe.
  - Outputs: word_full, word.
  - Cleared by the loader on start.
- Top FSM, word counter and address generation live in prog_loader.

## Test plan
- Reset: assert rst=0 mid-cycle → all outputs at reset values immediately; byte_ready=0, cpu_rst=1.
- Basic load: start, len=2, bytes 13 05 50 00 93 05 60 00 back-to-back → exactly two writes: (addr 0x0, 0x00500513) and (addr 0x4, 0x00600593). done=1 and cpu_rst=0 one cycle after the 2nd write.
- Stalled stream: same image with byte_valid low for 3 cycles between every byte → identical writes, no extra imem_we.
- Illegal len: start with len=0, then len=MAX_WORDS+1 → err=1, no imem_we, cpu_rst stays 1. A subsequent start with len=1 clears err and loads normally.
- Reset mid-load: after 6 bytes accepted of len=2, pulse rst low → no write for the second word. A restart with len=1 and bytes AA BB CC DD writes (addr 0x0, 0xDDCCBBAA).
- Restart and ignored start: start during LOAD is ignored and the word count is unchanged. After DONE, start with len=1 → cpu_rst=1 next cycle and done=0 until the new write completes.
